// File: rtl/uart_tx_scheduler.sv
// Round-robin response scheduler feeding one UART transmitter from echo, status,
// buffered gesture reports and dropped-gesture reports.
module uart_tx_scheduler #(
  parameter int GEST_FIFO_DEPTH = 4,
  parameter int HOLDOFF_CYCLES  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               echo_req,
  input  logic                               status_req,
  input  logic [2:0]                         status_bin,
  input  logic                               gesture_valid,
  input  logic [1:0]                         gesture,
  input  logic                               tx_busy,
  output logic [7:0]                         tx_data,
  output logic                               tx_valid,
  output logic [$clog2(GEST_FIFO_DEPTH):0]   fifo_count,
  output logic [3:0]                         drop_count,
  output logic [1:0]                         dbg_state,
  output logic [1:0]                         dbg_rr
);
  localparam int AW = $clog2(GEST_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t        state;
  logic [1:0]    rr;
  logic          echo_pend;
  logic          status_pend;
  logic [2:0]    bin_q;
  logic [1:0]    fifo_mem [GEST_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [HW-1:0] hold_cnt;

  logic [3:0]    pend;
  logic          found;
  logic [1:0]    cand;
  logic          grant_en;
  logic [1:0]    grant_idx;
  logic [7:0]    grant_byte;
  logic [2:0]    send_bin;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          drop_evt;
  logic          grant_drop;

  // Echo and status requests arriving this cycle are already visible to the
  // arbiter so a lone request reaches tx_valid on the next cycle.
  always_comb begin
    pend      = {drop_count != 4'd0, fifo_count != '0,
                 status_pend | status_req, echo_pend | echo_req};
    found     = 1'b0;
    cand      = rr;
    grant_idx = rr;
    for (int i = 0; i < 4; i++) begin
      cand = rr + 2'(i);
      if (!found && pend[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_en   = (state == S_IDLE) && !tx_busy && found;
    send_bin   = status_pend ? bin_q : status_bin;
    case (grant_idx)
      2'd0:    grant_byte = 8'h55;
      2'd1:    grant_byte = {4'hB, 1'b0, send_bin};
      2'd2:    grant_byte = {4'hA, 2'b00, fifo_mem[rd_ptr]};
      default: grant_byte = {4'hC, drop_count};
    endcase
    fifo_full  = (fifo_count == CW'(GEST_FIFO_DEPTH));
    pop        = grant_en && (grant_idx == 2'd2);
    grant_drop = grant_en && (grant_idx == 2'd3);
    push_ok    = gesture_valid && (!fifo_full || pop);
    drop_evt   = gesture_valid && fifo_full && !pop;
  end

  // Handshake: tx_valid is a single-cycle strobe with tx_data stable alongside;
  // there is no ready, the transmitter signals occupancy through tx_busy, which
  // is only trusted once the holdoff window after a strobe has elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr          <= 2'd0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      hold_cnt    <= '0;
      echo_pend   <= 1'b0;
      status_pend <= 1'b0;
      bin_q       <= 3'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      drop_count  <= 4'd0;
    end else begin
      tx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_en) begin
            tx_data  <= grant_byte;
            tx_valid <= 1'b1;
            rr       <= grant_idx + 2'd1;
            hold_cnt <= '0;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) state <= S_DRAIN;
          else hold_cnt <= hold_cnt + 1'b1;
        end
        S_DRAIN: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A new request in its own grant cycle survives only if one was already queued.
      if (grant_en && grant_idx == 2'd0) echo_pend <= echo_pend & echo_req;
      else if (echo_req)                 echo_pend <= 1'b1;

      if (grant_en && grant_idx == 2'd1) status_pend <= status_pend & status_req;
      else if (status_req)               status_pend <= 1'b1;
      if (status_req) bin_q <= status_bin;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (grant_drop)                          drop_count <= drop_evt ? 4'd1 : 4'd0;
      else if (drop_evt && drop_count != 4'hF) drop_count <= drop_count + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= gesture;
  end

  assign dbg_state = state;
  assign dbg_rr    = rr;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: hand-computed byte sequences, occupancy
// and drop counts, with a simple UART busy model driven from the main sequence.
module tb_uart_tx_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       echo_req = 1'b0;
  logic       status_req = 1'b0;
  logic [2:0] status_bin = 3'd0;
  logic       gesture_valid = 1'b0;
  logic [1:0] gesture = 2'd0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [2:0] fifo_count;
  logic [3:0] drop_count;
  logic [1:0] dbg_state;
  logic [1:0] dbg_rr;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_tx_scheduler #(.GEST_FIFO_DEPTH(4), .HOLDOFF_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .echo_req(echo_req), .status_req(status_req),
    .status_bin(status_bin), .gesture_valid(gesture_valid), .gesture(gesture),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid),
    .fifo_count(fifo_count), .drop_count(drop_count),
    .dbg_state(dbg_state), .dbg_rr(dbg_rr)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    echo_req = 1'b0;
    status_req = 1'b0;
    status_bin = 3'd0;
    gesture_valid = 1'b0;
    gesture = 2'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    tx_busy = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // UART model: busy for busy_len cycles after each strobe; pulses are cleared after the first cycle
  task automatic run_uart(input int cycles, input int busy_len);
    int   remain;
    logic busy_prev;
    remain = 0;
    tx_busy = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      busy_prev = tx_busy;
      tick();
      if (i == 0) clear_inputs();
      if (tx_valid) begin
        chk("strobe_while_busy", {31'd0, busy_prev}, 32'd0);
        got_q.push_back(tx_data);
        tx_busy = 1'b1;
        remain = busy_len;
      end else if (remain > 0) begin
        remain--;
        if (remain == 0) tx_busy = 1'b0;
      end
    end
    tx_busy = 1'b0;
  endtask

  // Scoreboard
  task automatic check_bytes(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_drop_count", {28'd0, drop_count}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_rr", {30'd0, dbg_rr}, 32'd0);
    rst = 1'b0;

    // Echo alone: strobe one cycle after the pulse, exactly once
    do_reset();
    echo_req = 1'b1;
    tick();
    echo_req = 1'b0;
    chk("echo_valid", {31'd0, tx_valid}, 32'd1);
    chk("echo_data", {24'd0, tx_data}, 32'h55);
    tick();
    chk("echo_one_cycle", {31'd0, tx_valid}, 32'd0);
    run_uart(30, 5);
    check_bytes("echo_extra");

    // Contention: echo, status bin 5, gesture 2 together
    do_reset();
    echo_req = 1'b1;
    status_req = 1'b1;
    status_bin = 3'd5;
    gesture_valid = 1'b1;
    gesture = 2'd2;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hB5);
    exp_q.push_back(8'hA2);
    run_uart(3100, 1000);
    check_bytes("contention");
    chk("contention_rr", {30'd0, dbg_rr}, 32'd3);

    // Round-robin fairness: echo slips in after the first gesture
    do_reset();
    gesture_valid = 1'b1;
    gesture = 2'd0;
    tick();
    gesture = 2'd1;
    tick();
    chk("rr_first_valid", {31'd0, tx_valid}, 32'd1);
    chk("rr_first_data", {24'd0, tx_data}, 32'hA0);
    tx_busy = 1'b1;
    gesture = 2'd2;
    echo_req = 1'b1;
    tick();
    gesture = 2'd3;
    echo_req = 1'b0;
    tick();
    gesture_valid = 1'b0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    run_uart(120, 10);
    check_bytes("rr_fair");

    // Overflow: 7 gestures against a busy line
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      gesture_valid = 1'b1;
      gesture = 2'd3;
      tick();
      chk("ovf_no_strobe", {31'd0, tx_valid}, 32'd0);
    end
    gesture_valid = 1'b0;
    chk("ovf_fifo_count", {29'd0, fifo_count}, 32'd4);
    chk("ovf_drop_count", {28'd0, drop_count}, 32'd3);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA3);
    run_uart(300, 20);
    check_bytes("ovf");
    chk("ovf_drop_after", {28'd0, drop_count}, 32'd0);
    chk("ovf_fifo_after", {29'd0, fifo_count}, 32'd0);

    // Case 1: new status request in the grant cycle of a pending one
    do_reset();
    tx_busy = 1'b1;
    status_req = 1'b1;
    status_bin = 3'd6;
    tick();
    status_req = 1'b0;
    status_bin = 3'd0;
    chk("st_held_off", {31'd0, tx_valid}, 32'd0);
    tx_busy = 1'b0;
    status_req = 1'b1;
    status_bin = 3'd1;
    tick();
    status_req = 1'b0;
    chk("st_first_valid", {31'd0, tx_valid}, 32'd1);
    chk("st_first_data", {24'd0, tx_data}, 32'hB6);
    exp_q.push_back(8'hB1);
    run_uart(40, 5);
    check_bytes("st_second");

    // Case 2: gesture dropped in the drop-report grant cycle
    do_reset();
    gesture_valid = 1'b1;
    gesture = 2'd0;
    tick();
    gesture_valid = 1'b0;
    tick();
    chk("dr_first_data", {24'd0, tx_data}, 32'hA0);
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gesture_valid = 1'b1;
      gesture = 2'd1;
      tick();
    end
    gesture_valid = 1'b0;
    chk("dr_fifo_full", {29'd0, fifo_count}, 32'd4);
    chk("dr_drop_one", {28'd0, drop_count}, 32'd1);
    tx_busy = 1'b0;
    tick();
    gesture_valid = 1'b1;
    gesture = 2'd2;
    tick();
    gesture_valid = 1'b0;
    chk("dr_grant_valid", {31'd0, tx_valid}, 32'd1);
    chk("dr_grant_data", {24'd0, tx_data}, 32'hC1);
    chk("dr_count_after", {28'd0, drop_count}, 32'd1);
    chk("dr_fifo_after", {29'd0, fifo_count}, 32'd4);

    // Reset during HOLD with 3 queued gestures
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gesture_valid = 1'b1;
      gesture = 2'd1;
      tick();
    end
    gesture_valid = 1'b0;
    tx_busy = 1'b0;
    tick();
    chk("mid_valid", {31'd0, tx_valid}, 32'd1);
    chk("mid_state_hold", {30'd0, dbg_state}, 32'd1);
    chk("mid_fifo", {29'd0, fifo_count}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_fifo", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("mid_rst_rr", {30'd0, dbg_rr}, 32'd0);
    run_uart(40, 5);
    check_bytes("mid_quiet");
    echo_req = 1'b1;
    exp_q.push_back(8'h55);
    run_uart(40, 5);
    check_bytes("mid_new_req");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
